// File: rtl/debug_reg_dumper.sv
// debug_reg_dumper: walks the register-file debug port x0..x31 on request and
// streams each word MSB byte first as 8N1 UART bytes, preceded by SYNC_BYTE.
// Optional build macro: DUMP_PC_EN inserts the program counter word between the
// sync byte and x0.
module debug_reg_dumper #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] Debug_out,
    input  logic [31:0] PC,
    output logic [4:0]  Debug_Source_select,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [4:0]      word_idx_q, word_idx_d;
    logic            sync_q, sync_d;      // current byte is the frame header
    logic [7:0]      byte_q, byte_d;      // byte on the wire
    logic [31:0]     word_q, word_d;      // snapshot of the word being sent
    logic [4:0]      sel_q, sel_d;
    logic            done_q, done_d;
    logic            bit_end;

`ifdef DUMP_PC_EN
    logic            pc_slot_q, pc_slot_d;
`else
    logic            unused_pc;
    assign unused_pc = ^PC;
`endif

    assign bit_end = (bit_cnt_q == CntMax);

    // Next-state: bit timing, byte sequencing and word capture
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        sync_d     = sync_q;
        byte_d     = byte_q;
        word_d     = word_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
`ifdef DUMP_PC_EN
        pc_slot_d  = pc_slot_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StStart;
                    byte_d     = SYNC_BYTE;
                    sync_d     = 1'b1;
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = StStop;
                        // Present the next word's index a full stop bit before capture
                        if (!sync_q && byte_idx_q == 2'd3 && word_idx_q != 5'd31
`ifdef DUMP_PC_EN
                            && !pc_slot_q
`endif
                        ) begin
                            sel_d = word_idx_q + 5'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = StStart;
                    if (sync_q) begin
                        sync_d = 1'b0;
`ifdef DUMP_PC_EN
                        pc_slot_d = 1'b1;
                        byte_d    = PC[31:24];
                        word_d    = PC;
`else
                        byte_d    = Debug_out[31:24];
                        word_d    = Debug_out;
`endif
                    end else if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0:    byte_d = word_q[23:16];
                            2'd1:    byte_d = word_q[15:8];
                            default: byte_d = word_q[7:0];
                        endcase
`ifdef DUMP_PC_EN
                    end else if (pc_slot_q) begin
                        pc_slot_d  = 1'b0;
                        byte_idx_d = '0;
                        byte_d     = Debug_out[31:24];
                        word_d     = Debug_out;
`endif
                    end else if (word_idx_q != 5'd31) begin
                        word_idx_d = word_idx_q + 5'd1;
                        byte_idx_d = '0;
                        byte_d     = Debug_out[31:24];
                        word_d     = Debug_out;
                    end else begin
                        state_d    = StIdle;
                        done_d     = 1'b1;
                        sel_d      = '0;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line driver: idle/stop high, start low, data LSB first
    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = byte_q[bit_idx_q];
            default: tx = 1'b1;
        endcase
        busy                = (state_q != StIdle);
        done                = done_q;
        Debug_Source_select = sel_q;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            sync_q     <= 1'b0;
            byte_q     <= '0;
            word_q     <= '0;
            sel_q      <= '0;
            done_q     <= 1'b0;
`ifdef DUMP_PC_EN
            pc_slot_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            sync_q     <= sync_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
`ifdef DUMP_PC_EN
            pc_slot_q  <= pc_slot_d;
`endif
        end
    end

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Self-checking bench for debug_reg_dumper with CLKS_PER_BIT=4. The reference
// model builds the expected byte stream from the register array and PC, then
// derives the exact 40-cycle waveform of each 8N1 byte arithmetically.
module tb_debug_reg_dumper;

    localparam int unsigned Cpb = 4;
    localparam logic [7:0] Sync = 8'hA5;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] debug_out;
    logic [31:0] pc;
    logic [4:0]  sel;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [7:0]  last_rx [133];
    int          last_nb;
    int          n_checks;
    int          n_fail;

    debug_reg_dumper #(
        .CLKS_PER_BIT(Cpb),
        .SYNC_BYTE   (Sync)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .Debug_out          (debug_out),
        .PC                 (pc),
        .Debug_Source_select(sel),
        .tx                 (tx),
        .busy               (busy),
        .done               (done)
    );

    // Combinational register-file debug read
    assign debug_out = regs[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_pattern();
        for (int n = 0; n < 32; n++) regs[n] = 32'h0101_0100 * n + n;
    endtask

    task automatic load_random();
        for (int n = 0; n < 32; n++) regs[n] = $urandom;
    endtask

    // One full frame from the start edge through the done edge.
    task automatic run_frame(input bit hold, input bit pulse_busy, input bit mutate);
        logic [7:0]  exp_b [$];
        logic [39:0] obs;
        logic [39:0] expv;
        logic [7:0]  b;
        logic [7:0]  rxb;
        int          nb;
        int          off;
        int          t;
        int          p;
        bit          busy_bad;
        bit          done_bad;
        exp_b.push_back(Sync);
`ifdef DUMP_PC_EN
        for (int k = 3; k >= 0; k--) exp_b.push_back(pc[8*k +: 8]);
`endif
        for (int w = 0; w < 32; w++) begin
            for (int k = 3; k >= 0; k--) exp_b.push_back(regs[w][8*k +: 8]);
        end
        nb       = exp_b.size();
        off      = nb - 128;
        busy_bad = 1'b0;
        done_bad = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = hold;
        for (int j = 0; j < nb; j++) begin
            obs = '0;
            for (int i = 0; i < 40; i++) begin
                t = j * 40 + i + 1;
                if (i == 0) begin
                    check_eq("sel_at_byte", 64'(sel), (j < off) ? 64'd0 : 64'((j - off) / 4));
                    // Word already latched: changing the source must not disturb it
                    if (mutate && j >= off && ((j - off) % 4) == 0)
                        regs[(j - off) / 4] = $urandom;
                end
                obs[i] = tx;
                if (busy !== 1'b1) busy_bad = 1'b1;
                if (done !== 1'b0) done_bad = 1'b1;
                if (pulse_busy) begin
                    if (t == 50 || t == 300) start = 1'b1;
                    if (t == 51 || t == 301) start = 1'b0;
                end
                if (!(j == nb - 1 && i == 39)) begin
                    @(posedge clk);
                    #1;
                end
            end
            b = exp_b[j];
            for (int i = 0; i < 40; i++) begin
                p = i / 4;
                expv[i] = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : b[p - 1];
            end
            check_eq("byte_wave", 64'(obs), 64'(expv));
            for (int n = 0; n < 8; n++) rxb[n] = obs[4 * (n + 1) + 2];
            last_rx[j] = rxb;
        end
        last_nb = nb;
        @(posedge clk);
        #1;
        check_eq("done_at_end", 64'(done), 64'd1);
        check_eq("busy_at_end", 64'(busy), 64'd0);
        check_eq("tx_at_end", 64'(tx), 64'd1);
        check_eq("sel_wrap", 64'(sel), 64'd0);
        check_eq("busy_in_frame", 64'(busy_bad), 64'd0);
        check_eq("done_early", 64'(done_bad), 64'd0);
        check_eq("rx_sync", 64'(last_rx[0]), 64'(Sync));
        if (!hold) begin
            @(posedge clk);
            #1;
            check_eq("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    initial begin
        bit bad;
        int off;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        pc       = 32'h0000_0040;
        load_pattern();

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx", 64'(tx), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_sel", 64'(sel), 64'd0);
        reset = 1'b0;
        bad   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || sel !== 5'd0) bad = 1'b1;
        end
        check_eq("idle_stable", 64'(bad), 64'd0);

        // Full frame with the patterned register file
        run_frame(1'b0, 1'b0, 1'b0);
        off = last_nb - 128;
        check_eq("frame_len", 64'(last_nb),
`ifdef DUMP_PC_EN
                 64'd133);
        check_eq("pc_bytes", 64'({last_rx[1], last_rx[2], last_rx[3], last_rx[4]}), 64'h40);
`else
                 64'd129);
`endif
        check_eq("x1_bytes", 64'({last_rx[off+4], last_rx[off+5], last_rx[off+6], last_rx[off+7]}),
                 64'h0101_0101);
        check_eq("x31_bytes", 64'({last_rx[off+124], last_rx[off+125], last_rx[off+126],
                 last_rx[off+127]}), 64'h1F1F_1F1F);

        // Start while busy is ignored and not queued
        run_frame(1'b0, 1'b1, 1'b0);
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        check_eq("no_queue", 64'(bad), 64'd0);

        // Start held through done: back-to-back frames
        load_random();
        run_frame(1'b1, 1'b0, 1'b0);
        load_random();
        run_frame(1'b0, 1'b0, 1'b1);

        // Reset during byte 40
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40 * 40 + 13) @(posedge clk);
        #1;
        check_eq("busy_before_rst", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("midrst_tx", 64'(tx), 64'd1);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        check_eq("midrst_quiet", 64'(bad), 64'd0);

        // Reset and start together: reset wins
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        check_eq("rst_wins", 64'(busy), 64'd0);

        // Complete frame after the interrupted one, random contents and PC
        load_random();
        pc = $urandom;
        run_frame(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_reg_dumper.md
# debug_reg_dumper

Debug-port reader for the single-cycle RISC-V datapath. On a start request it walks the register file's debug read port (Debug_Source_select / Debug_out) through x0..x31 and streams every word off-chip as 8N1 UART bytes on one TX line. It sits beside the datapath at top level and is the consumer end of the datapath's debug interface. It needs no processor cooperation beyond the existing combinational debug read.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (868 = 100 MHz / 115200); legal range ≥ 2
- SYNC_BYTE, 8'hA5, frame header byte sent before register data

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; one clock, and the reset is synchronous and active-high
- start  input  1  request a dump; sampled only in IDLE
- Debug_out  input  32  register value returned by the datapath for Debug_Source_select
- PC  input  32  current program counter; used only when DUMP_PC_EN is defined
- Debug_Source_select  output  5  register index presented to the datapath debug port
- tx  output  1  UART serial out, idle high
- busy  output  1  high while a frame is in progress
- done  output  1  one-cycle pulse at frame end

## Operation
- Frame: SYNC_BYTE, then [PC word if DUMP_PC_EN], then x0..x31. Each word is sent as 4 bytes, MSB byte first. Each byte is 8N1: start bit 0, data LSB first, stop bit 1.
- Frame length: 129 bytes, or 133 with DUMP_PC_EN.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT. Counters:
  - bit_cnt 0..CLKS_PER_BIT-1
  - bit_idx 0..7
  - byte_idx 0..3
  - word_idx 0..31 (plus a PC slot when enabled)
- IDLE:
  - tx=1, busy=0
  - Debug_Source_select holds 0
  - start=1 loads SYNC_BYTE into the shift register and moves to START_BIT
- START_BIT → DATA_BITS → STOP_BIT; each bit is held exactly CLKS_PER_BIT cycles.
- After STOP_BIT completes:
  - more bytes pending: load the next byte and go straight to START_BIT, with no idle gap
  - last byte: go to IDLE and pulse done
- Word capture:
  - At the first cycle of the stop bit preceding a word's first byte, Debug_Source_select is driven to that word's index.
  - Debug_out is latched into a 32-bit word register on the edge that enters that word's START_BIT.
  - Bytes 1..3 of the word come from the latched copy.
- Coherency: each word is a snapshot at its own capture edge. Frame-wide atomicity is not guaranteed unless the CPU is halted.
- start while busy: ignored, with no queueing. start held high at frame end begins a new frame on the edge after done.
- Debug_Source_select wraps at the end of the frame: after x31 it returns to 0 on the edge entering IDLE.

## Timing
- Reset values: tx=1, busy=0, done=0, Debug_Source_select=0; FSM in IDLE; all counters 0.
- start sampled high at edge k:
  - tx=0 and busy=1 after edge k
  - the start bit occupies cycles k+1 .. k+CLKS_PER_BIT
- Frame duration: exactly bytes × 10 × CLKS_PER_BIT cycles, from edge k to the final stop-bit end.
- done is high for one cycle, starting at the edge that ends the last stop bit; busy drops on that same edge.
- Debug_Source_select settles ≥ CLKS_PER_BIT cycles before capture. This covers the datapath's combinational read path.
- Reset mid-frame: on the next edge tx=1, busy=0, done=0 with no pulse, and state is IDLE. The truncated byte is not completed.
- reset and start high together: reset wins.

## Configuration
- DUMP_PC_EN defined:
  - a PC slot is inserted between SYNC_BYTE and x0
  - PC is latched on the edge entering that slot's START_BIT
  - Debug_Source_select holds 0 during the PC slot
  - frame is 133 bytes
- DUMP_PC_EN undefined:
  - the PC port is present but ignored
  - frame is 129 bytes; no PC-slot logic is synthesized

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset and idle: reset for 2 cycles → tx=1, busy=0, done=0, Debug_Source_select=0. Holding start=0 for 100 cycles leaves all outputs unchanged.
- Full frame: model the register file as xN=32'h0101_0100*N+N, pulse start → 129 bytes decoded.
  - byte0 = 8'hA5
  - x1 arrives as 01,01,01,01 (MSB byte first)
  - x31 arrives as 1F,1F,1F,1F
  - done pulses exactly 5160 cycles after the start edge
- Bit timing: x0=0 → every bit is exactly 4 cycles wide, LSB first, no gaps between bytes, stop bit = 1.
- Start while busy: pulse start at cycle 50 and cycle 300 → only one frame is sent. Holding start high through done starts a second frame on the next edge.
- Reset mid-frame: assert reset during byte 40 → tx=1 on the next edge, no done pulse. A following start sends a complete frame beginning with 8'hA5.
- DUMP_PC_EN with PC=32'h0000_0040: frame is 133 bytes with bytes 1..4 = 00,00,00,40. done pulses at cycle 5320.
